jt49_bus_fifo: RTL and testbench

Parametrised bus front-end for one or more jt49 PSG cores. It decodes the full three-pin AY bus (BDIR/BC2/BC1) and latches a register address plus chip number. CPU writes are buffered in a FIFO and replayed to the selected core at most once per `clk_en`, with a registered read path back to the bus. It sits between a CPU bus and up to four jt49 instances sharing one clock.

---
 rtl/jt49_bus_fifo.sv | 143 ++++++++++++++
 tb/tb_jt49_bus_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_fifo.sv
// AY bus (BDIR/BC2/BC1) front-end: latches address/chip, buffers writes in a FIFO drained once per clk_en.
// Latency: push-to-strobe >= 1 clk, READ -> dout 1 clk; full FIFO drops writes and sets sticky ovf.
module jt49_bus_fifo #(
    parameter int NCHIPS = 2,
    parameter int DEPTHW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  bdir,
    input  logic                  bc2,
    input  logic                  bc1,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  busy,
    output logic                  full,
    output logic                  ovf,
    output logic [3:0]            core_addr,
    output logic [7:0]            core_din,
    output logic                  core_wr_n,
    output logic [NCHIPS-1:0]     core_cs_n,
    input  logic [8*NCHIPS-1:0]   core_dout
);
    localparam int DEPTH = 2**DEPTHW;
    localparam logic [DEPTHW:0] DEPTH_C = (DEPTHW+1)'(DEPTH);
    localparam logic [2:0]      NCH_C   = 3'(NCHIPS);

    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_READ, ST_WRITE} bus_st_t;

    bus_st_t                bus_st, prev_q;
    logic [3:0]             lat_addr_q;
    logic [1:0]             lat_chip_q;
    logic                   sel_ok_q;
    logic [13:0]            mem_q [DEPTH];
    logic [DEPTHW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DEPTHW:0]        count_q, count_d;
    logic                   busy_q, full_q, ovf_q;
    logic                   stb_q;
    logic [3:0]             stb_addr_q;
    logic [7:0]             core_din_q, dout_q, dout_d, rd_sel;
    logic [NCHIPS-1:0]      cs_n_q, cs_n_d;
    logic                   latch_ev, write_ev, push, pop, push_ok;
    logic [13:0]            head;

    always_comb begin
        case ({bdir, bc2, bc1})
            3'b001, 3'b100, 3'b111: bus_st = ST_LATCH;
            3'b011:                 bus_st = ST_READ;
            3'b110:                 bus_st = ST_WRITE;
            default:                bus_st = ST_IDLE;
        endcase
    end

    // Actions fire only on entry into a bus state, never while it is held.
    assign latch_ev = (bus_st == ST_LATCH) && (prev_q != ST_LATCH);
    assign write_ev = (bus_st == ST_WRITE) && (prev_q != ST_WRITE);
    assign push     = write_ev && sel_ok_q;
    assign pop      = clk_en && (count_q != '0);
    assign push_ok  = push && ((count_q < DEPTH_C) || pop);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        cs_n_d = '1;
        rd_sel = 8'hFF;
        for (int k = 0; k < NCHIPS; k++) begin
            if (pop && head[13:12] == 2'(k))
                cs_n_d[k] = 1'b0;
            if (lat_chip_q == 2'(k))
                rd_sel = core_dout[8*k +: 8];
        end
    end

    // core_addr shows the FIFO entry during a strobe, so the read sample is skipped then.
    always_comb begin
        dout_d = dout_q;
        if (bus_st == ST_READ && !stb_q)
            dout_d = sel_ok_q ? rd_sel : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {lat_chip_q, lat_addr_q, din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= ST_IDLE;
            lat_addr_q <= 4'd0;
            lat_chip_q <= 2'd0;
            sel_ok_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            stb_q      <= 1'b0;
            stb_addr_q <= 4'd0;
            core_din_q <= 8'd0;
            cs_n_q     <= '1;
            dout_q     <= 8'hFF;
        end else begin
            prev_q <= bus_st;
            if (latch_ev) begin
                lat_addr_q <= din[3:0];
                lat_chip_q <= din[5:4];
                sel_ok_q   <= (din[7:6] == 2'b00) && ({1'b0, din[5:4]} < NCH_C);
            end
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                stb_addr_q <= head[11:8];
                core_din_q <= head[7:0];
            end
            if (push && !push_ok)
                ovf_q <= 1'b1;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
            full_q  <= (count_d == DEPTH_C);
            stb_q   <= pop;
            cs_n_q  <= cs_n_d;
            dout_q  <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign ovf       = ovf_q;
    assign core_addr = stb_q ? stb_addr_q : lat_addr_q;
    assign core_din  = core_din_q;
    assign core_wr_n = ~stb_q;
    assign core_cs_n = cs_n_q;
endmodule

// File: tb/tb_jt49_bus_fifo.sv
// Directed bench for jt49_bus_fifo (NCHIPS=2, DEPTHW=3) with hand-computed expectations.
module tb_jt49_bus_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        bdir, bc2, bc1;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        busy, full, ovf;
    logic [3:0]  core_addr;
    logic [7:0]  core_din;
    logic        core_wr_n;
    logic [1:0]  core_cs_n;
    logic [15:0] core_dout;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] B_IDLE  = 3'b000;
    localparam logic [2:0] B_LATCH = 3'b111;
    localparam logic [2:0] B_READ  = 3'b011;
    localparam logic [2:0] B_WRITE = 3'b110;

    jt49_bus_fifo #(.NCHIPS(2), .DEPTHW(3)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .bdir(bdir), .bc2(bc2), .bc1(bc1), .din(din),
        .dout(dout), .busy(busy), .full(full), .ovf(ovf),
        .core_addr(core_addr), .core_din(core_din),
        .core_wr_n(core_wr_n), .core_cs_n(core_cs_n),
        .core_dout(core_dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [2:0] s, input logic [7:0] d);
        {bdir, bc2, bc1} = s;
        din = d;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b0;
        core_dout = 16'h0000;
        bus(B_IDLE, 8'h00);
        tick();
        tick();
        chk("rst_dout", 16'(dout), 16'h00FF);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_full", 16'(full), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        chk("rst_addr", 16'(core_addr), 16'd0);
        chk("rst_din", 16'(core_din), 16'd0);
        chk("rst_wr_n", 16'(core_wr_n), 16'd1);
        chk("rst_cs_n", 16'(core_cs_n), 16'h3);
        rst = 1'b0;
        tick();

        // Latch chip 1 addr 7, then a WRITE held for 4 cycles gives one strobe.
        bus(B_LATCH, 8'h17);
        tick();
        chk("lat_addr", 16'(core_addr), 16'd7);
        bus(B_WRITE, 8'hA5);
        clk_en = 1'b1;
        tick();
        chk("wr_busy", 16'(busy), 16'd1);
        chk("wr_nostb", 16'(core_wr_n), 16'd1);
        tick();
        chk("stb_wr_n", 16'(core_wr_n), 16'd0);
        chk("stb_addr", 16'(core_addr), 16'd7);
        chk("stb_din", 16'(core_din), 16'hA5);
        chk("stb_cs_n", 16'(core_cs_n), 16'b01);
        chk("stb_busy", 16'(busy), 16'd0);
        tick();
        chk("hold_wr_n1", 16'(core_wr_n), 16'd1);
        chk("hold_cs_n", 16'(core_cs_n), 16'h3);
        chk("hold_din", 16'(core_din), 16'hA5);
        tick();
        chk("hold_wr_n2", 16'(core_wr_n), 16'd1);
        bus(B_IDLE, 8'h00);
        clk_en = 1'b0;
        tick();

        // Fill with clk_en low: 8 accepted, 9th dropped.
        bus(B_LATCH, 8'h02);
        tick();
        bus(B_IDLE, 8'h00);
        tick();
        for (int i = 0; i < 9; i++) begin
            bus(B_WRITE, 8'h10 + 8'(i));
            tick();
            if (i == 6) chk("fill_full6", 16'(full), 16'd0);
            if (i == 7) begin
                chk("fill_full8", 16'(full), 16'd1);
                chk("fill_ovf8", 16'(ovf), 16'd0);
            end
            if (i == 8) begin
                chk("fill_full9", 16'(full), 16'd1);
                chk("fill_ovf9", 16'(ovf), 16'd1);
            end
            bus(B_IDLE, 8'h00);
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            clk_en = 1'b1;
            tick();
            clk_en = 1'b0;
            chk("drain_wr_n", 16'(core_wr_n), 16'd0);
            chk("drain_din", 16'(core_din), 16'h10 + 16'(j));
            chk("drain_addr", 16'(core_addr), 16'd2);
            chk("drain_cs_n", 16'(core_cs_n), 16'b10);
            tick();
            chk("drain_gap", 16'(core_wr_n), 16'd1);
            tick();
            tick();
        end
        chk("drain_busy", 16'(busy), 16'd0);
        chk("drain_ovf", 16'(ovf), 16'd1);
        clk_en = 1'b1;
        tick();
        tick();
        chk("drain_nomore", 16'(core_wr_n), 16'd1);
        clk_en = 1'b0;

        // Reset clears the sticky overflow.
        rst = 1'b1;
        #2;
        chk("rst2_ovf", 16'(ovf), 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 8; i++) begin
            bus(B_WRITE, 8'h20 + 8'(i));
            tick();
            bus(B_IDLE, 8'h00);
            tick();
        end
        chk("pp_full_pre", 16'(full), 16'd1);
        bus(B_WRITE, 8'h28);
        clk_en = 1'b1;
        tick();
        chk("pp_full", 16'(full), 16'd1);
        chk("pp_ovf", 16'(ovf), 16'd0);
        chk("pp_wr_n", 16'(core_wr_n), 16'd0);
        chk("pp_din", 16'(core_din), 16'h20);
        chk("pp_cs_n", 16'(core_cs_n), 16'b10);
        bus(B_IDLE, 8'h00);
        tick();
        chk("pp_din2", 16'(core_din), 16'h21);
        chk("pp_full2", 16'(full), 16'd0);

        // Asynchronous reset in the middle of a strobe.
        rst = 1'b1;
        #2;
        chk("mid_wr_n", 16'(core_wr_n), 16'd1);
        chk("mid_cs_n", 16'(core_cs_n), 16'h3);
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_full", 16'(full), 16'd0);
        chk("mid_dout", 16'(dout), 16'h00FF);
        chk("mid_ovf", 16'(ovf), 16'd0);
        chk("mid_din", 16'(core_din), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mid_after_wr_n", 16'(core_wr_n), 16'd1);
        chk("mid_after_busy", 16'(busy), 16'd0);
        clk_en = 1'b0;

        // Invalid chip: writes ignored, reads return FF.
        bus(B_LATCH, 8'h35);
        tick();
        bus(B_WRITE, 8'h99);
        tick();
        chk("bad_busy", 16'(busy), 16'd0);
        chk("bad_ovf", 16'(ovf), 16'd0);
        core_dout = 16'h3C5A;
        bus(B_READ, 8'h00);
        tick();
        chk("bad_read", 16'(dout), 16'h00FF);
        bus(B_LATCH, 8'h12);
        tick();
        bus(B_READ, 8'h00);
        tick();
        chk("read_c1", 16'(dout), 16'h003C);
        chk("read_addr", 16'(core_addr), 16'd2);
        bus(B_LATCH, 8'h05);
        tick();
        bus(B_READ, 8'h00);
        tick();
        chk("read_c0", 16'(dout), 16'h005A);

        // READ held across a write strobe.
        bus(B_LATCH, 8'h12);
        tick();
        bus(B_WRITE, 8'h77);
        tick();
        chk("rs_busy", 16'(busy), 16'd1);
        core_dout = 16'h4D5A;
        bus(B_READ, 8'h00);
        tick();
        chk("rs_pre", 16'(dout), 16'h004D);
        core_dout = 16'h6E5A;
        clk_en = 1'b1;
        tick();
        chk("rs_popedge", 16'(dout), 16'h006E);
        chk("rs_wr_n", 16'(core_wr_n), 16'd0);
        chk("rs_din", 16'(core_din), 16'h77);
        chk("rs_addr", 16'(core_addr), 16'd2);
        chk("rs_cs_n", 16'(core_cs_n), 16'b01);
        core_dout = 16'h7F5A;
        clk_en = 1'b0;
        tick();
        chk("rs_skip", 16'(dout), 16'h006E);
        chk("rs_wr_n2", 16'(core_wr_n), 16'd1);
        tick();
        chk("rs_update", 16'(dout), 16'h007F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
